writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage_pkg.sv | 25 ++
 rtl/writeback_stage_load_align.sv | 38 +++
 rtl/writeback_stage.sv | 142 ++++++++++++++
 tb/tb_writeback_stage.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_stage_pkg.sv
// Shared types and constants for the writeback stage.
package writeback_stage_pkg;

  localparam int XLEN_DEFAULT       = 64;
  localparam int REG_ADDR_W_DEFAULT = 5;

  // Writeback sequencing: capture in IDLE, one write cycle, then hold the
  // acknowledge until the memory stage drops its offer.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } wb_state_t;

  // Load size/sign encodings carried in funct3.
  localparam logic [2:0] F3_LB     = 3'b000;
  localparam logic [2:0] F3_LH     = 3'b001;
  localparam logic [2:0] F3_LW     = 3'b010;
  localparam logic [2:0] F3_LD     = 3'b011;
  localparam logic [2:0] F3_LBU    = 3'b100;
  localparam logic [2:0] F3_LHU    = 3'b101;
  localparam logic [2:0] F3_LWU    = 3'b110;
  localparam logic [2:0] F3_LD_ALT = 3'b111;

endpackage

// File: rtl/writeback_stage_load_align.sv
// Combinational load alignment: shifts the returned doubleword down to the
// addressed byte (zero-filling from the top) and then sizes/extends it.
// Loads that cross the doubleword boundary just see the zero-filled bytes.
module writeback_stage_load_align
  import writeback_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] loaded_data,
  input  logic [2:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] shifted;

  // Byte-offset shift; the amount is offset*8.
  always_comb begin
    shifted = loaded_data >> {offset, 3'b000};
  end

  // Size selection with sign or zero extension; 111 behaves as a full LD.
  always_comb begin
    result = shifted;
    case (funct3)
      F3_LB:     result = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_LH:     result = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_LW:     result = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      F3_LBU:    result = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_LHU:    result = {{(XLEN-16){1'b0}}, shifted[15:0]};
      F3_LWU:    result = {{(XLEN-32){1'b0}}, shifted[31:0]};
      F3_LD,
      F3_LD_ALT: result = shifted;
      default:   result = shifted;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: captures a finished memory-stage result, writes the
// register file for exactly one cycle, releases the scoreboard entry, counts
// the retirement and then acknowledges with wb_done until the offer drops.
//
// Handshake: wb_enable acts as valid and is held high by the memory stage
// until wb_done is seen; a transfer is taken in IDLE on the edge where
// wb_enable && memory_done are both high. wb_done acts as the acknowledge and
// stays high from the cycle after the write until the edge after wb_enable
// falls. No new transfer is taken while WRITE or DONE is active.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_enable,
  input  logic                  memory_done,
  input  logic [XLEN-1:0]       loaded_data,
  input  logic [XLEN-1:0]       alu_data,
  input  logic [XLEN-1:0]       pc,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  reg_write,
  input  logic                  mem_to_reg,
  input  logic                  jump,
  input  logic [2:0]            funct3,
  output logic                  rf_write_enable,
  output logic [REG_ADDR_W-1:0] rf_write_addr,
  output logic [XLEN-1:0]       rf_write_data,
  output logic                  wb_done,
  output logic                  clear_busy,
  output logic [REG_ADDR_W-1:0] clear_busy_reg,
  output logic [63:0]           instret,
  output logic [1:0]            dbg_state
);

  wb_state_t state, state_next;

  logic [XLEN-1:0]       cap_loaded;
  logic [XLEN-1:0]       cap_alu;
  logic [XLEN-1:0]       cap_pc;
  logic [REG_ADDR_W-1:0] cap_rd;
  logic                  cap_reg_write;
  logic                  cap_mem_to_reg;
  logic                  cap_jump;
  logic [2:0]            cap_funct3;
  logic [63:0]           instret_q;

  logic [XLEN-1:0]       aligned_load;
  logic [XLEN-1:0]       wb_data;
  logic                  take;

  assign take      = (state == IDLE) && wb_enable && memory_done;
  assign instret   = instret_q;
  assign dbg_state = state;

  writeback_stage_load_align #(
    .XLEN (XLEN)
  ) u_load_align (
    .loaded_data (cap_loaded),
    .offset      (cap_alu[2:0]),
    .funct3      (cap_funct3),
    .result      (aligned_load)
  );

  // State register, input capture and retirement counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cap_loaded     <= '0;
      cap_alu        <= '0;
      cap_pc         <= '0;
      cap_rd         <= '0;
      cap_reg_write  <= 1'b0;
      cap_mem_to_reg <= 1'b0;
      cap_jump       <= 1'b0;
      cap_funct3     <= '0;
      instret_q      <= '0;
    end else begin
      state <= state_next;
      if (take) begin
        cap_loaded     <= loaded_data;
        cap_alu        <= alu_data;
        cap_pc         <= pc;
        cap_rd         <= rd;
        cap_reg_write  <= reg_write;
        cap_mem_to_reg <= mem_to_reg;
        cap_jump       <= jump;
        cap_funct3     <= funct3;
      end
      if (state == WRITE) begin
        instret_q <= instret_q + 64'd1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (take) state_next = WRITE;
      WRITE:   state_next = DONE;
      DONE:    if (!wb_enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Result select: link address beats loaded data beats ALU result.
  always_comb begin
    wb_data = cap_alu;
    if (cap_jump) begin
      wb_data = cap_pc + XLEN'(4);
    end else if (cap_mem_to_reg) begin
      wb_data = aligned_load;
    end
  end

  // Register-file, scoreboard and acknowledge outputs; the write cycle is
  // suppressed when reset lands on it.
  always_comb begin
    rf_write_enable = 1'b0;
    rf_write_addr   = '0;
    rf_write_data   = '0;
    clear_busy      = 1'b0;
    clear_busy_reg  = '0;
    wb_done         = 1'b0;
    if (state == WRITE && !reset) begin
      rf_write_addr  = cap_rd;
      rf_write_data  = wb_data;
      clear_busy_reg = cap_rd;
      if (cap_reg_write && (cap_rd != '0)) begin
        rf_write_enable = 1'b1;
        clear_busy      = 1'b1;
      end
    end
    if (state == DONE) begin
      wb_done = 1'b1;
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus random
// retirements checked against a behavioural load/writeback model.
module tb_writeback_stage;
  import writeback_stage_pkg::*;

  localparam int XLEN = 64;
  localparam int RW   = 5;

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic            wb_enable, memory_done;
  logic [XLEN-1:0] loaded_data, alu_data, pc;
  logic [RW-1:0]   rd;
  logic            reg_write, mem_to_reg, jump;
  logic [2:0]      funct3;
  logic            rf_write_enable, wb_done, clear_busy;
  logic [RW-1:0]   rf_write_addr, clear_busy_reg;
  logic [XLEN-1:0] rf_write_data;
  logic [63:0]     instret;
  logic [1:0]      dbg_state;

  writeback_stage #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
    .clk             (clk),
    .reset           (reset),
    .wb_enable       (wb_enable),
    .memory_done     (memory_done),
    .loaded_data     (loaded_data),
    .alu_data        (alu_data),
    .pc              (pc),
    .rd              (rd),
    .reg_write       (reg_write),
    .mem_to_reg      (mem_to_reg),
    .jump            (jump),
    .funct3          (funct3),
    .rf_write_enable (rf_write_enable),
    .rf_write_addr   (rf_write_addr),
    .rf_write_data   (rf_write_data),
    .wb_done         (wb_done),
    .clear_busy      (clear_busy),
    .clear_busy_reg  (clear_busy_reg),
    .instret         (instret),
    .dbg_state       (dbg_state)
  );

  // Scoreboard state
  logic [XLEN-1:0] exp_q[$];
  logic [63:0]     exp_instret;
  int errors = 0;
  int checks = 0;

  // Reference load: byte-shift then size/extend using plain arithmetic.
  function automatic logic [63:0] model_load(input logic [63:0] ld, input logic [2:0] off,
                                              input logic [2:0] f3);
    logic [63:0] s;
    logic [63:0] v;
    s = ld / (64'd1 << (8 * int'(off)));
    case (f3)
      3'd0, 3'd4: begin
        v = s % 64'd256;
        if (f3 == 3'd0 && v >= 64'd128) v = v - 64'd256;
      end
      3'd1, 3'd5: begin
        v = s % 64'd65536;
        if (f3 == 3'd1 && v >= 64'd32768) v = v - 64'd65536;
      end
      3'd2, 3'd6: begin
        v = s % 64'h1_0000_0000;
        if (f3 == 3'd2 && v >= 64'h8000_0000) v = v - 64'h1_0000_0000;
      end
      default: v = s;
    endcase
    return v;
  endfunction

  task automatic idle_inputs();
    wb_enable = 1'b0; memory_done = 1'b0;
    loaded_data = '0; alu_data = '0; pc = '0; rd = '0;
    reg_write = 1'b0; mem_to_reg = 1'b0; jump = 1'b0; funct3 = '0;
  endtask

  // One complete retirement with full-cycle checking.
  task automatic retire(input logic [63:0] a, input logic [63:0] p, input logic [63:0] l,
                        input logic [RW-1:0] r, input logic rw, input logic m2r,
                        input logic j, input logic [2:0] f3, input int hold, input string tag);
    logic [63:0] exp_data;
    logic        exp_we;
    logic [63:0] got;
    @(negedge clk);
    alu_data = a; pc = p; loaded_data = l; rd = r;
    reg_write = rw; mem_to_reg = m2r; jump = j; funct3 = f3;
    wb_enable = 1'b1; memory_done = 1'b1;
    exp_data = j ? p + 64'd4 : (m2r ? model_load(l, a[2:0], f3) : a);
    exp_we   = rw && (r != 0);
    if (exp_we) exp_q.push_back(exp_data);
    @(posedge clk);
    // Disturb the inputs right after capture; the write must use captured values.
    #1;
    alu_data = {$urandom, $urandom}; pc = {$urandom, $urandom};
    loaded_data = {$urandom, $urandom}; rd = RW'($urandom);
    reg_write = ~rw; jump = ~j; funct3 = 3'($urandom);
    @(negedge clk);
    checks++;
    if (rf_write_enable !== exp_we || clear_busy !== exp_we || wb_done !== 1'b0) begin
      errors++;
      $display("FAIL %s write_strobe: we=%b cb=%b done=%b, need we=%b cb=%b done=0",
               tag, rf_write_enable, clear_busy, wb_done, exp_we, exp_we);
    end
    if (rf_write_enable === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s unexpected_write: data=%h", tag, rf_write_data);
      end else begin
        got = exp_q.pop_front();
        if (rf_write_data !== got || rf_write_addr !== r || clear_busy_reg !== r) begin
          errors++;
          $display("FAIL %s write_data: addr=%0d data=%h busy_reg=%0d, need addr=%0d data=%h",
                   tag, rf_write_addr, rf_write_data, clear_busy_reg, r, got);
        end
      end
    end
    exp_instret = exp_instret + 64'd1;
    @(negedge clk);
    checks++;
    if (wb_done !== 1'b1 || rf_write_enable !== 1'b0 || instret !== exp_instret ||
        rf_write_addr !== '0 || rf_write_data !== '0 || clear_busy !== 1'b0 ||
        clear_busy_reg !== '0) begin
      errors++;
      $display("FAIL %s done_cycle: done=%b we=%b instret=%h addr=%0d data=%h, need done=1 we=0 instret=%h zeros",
               tag, wb_done, rf_write_enable, instret, rf_write_addr, rf_write_data, exp_instret);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (wb_done !== 1'b1 || rf_write_enable !== 1'b0 || instret !== exp_instret) begin
        errors++;
        $display("FAIL %s hold_%0d: done=%b we=%b instret=%h, need done=1 we=0 instret=%h",
                 tag, i, wb_done, rf_write_enable, instret, exp_instret);
      end
    end
    wb_enable = 1'b0; memory_done = 1'b0;
    @(negedge clk);
    checks++;
    if (wb_done !== 1'b0 || dbg_state !== 2'(IDLE) || rf_write_enable !== 1'b0) begin
      errors++;
      $display("FAIL %s release: done=%b state=%0d we=%b, need done=0 state=IDLE we=0",
               tag, wb_done, dbg_state, rf_write_enable);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    exp_instret = '0;
    @(negedge clk);
    checks++;
    if (rf_write_enable !== 1'b0 || rf_write_addr !== '0 || rf_write_data !== '0 ||
        wb_done !== 1'b0 || clear_busy !== 1'b0 || clear_busy_reg !== '0 ||
        instret !== 64'd0 || dbg_state !== 2'(IDLE)) begin
      errors++;
      $display("FAIL reset_state: we=%b addr=%0d data=%h done=%b cb=%b instret=%h state=%0d, need all zero/IDLE",
               rf_write_enable, rf_write_addr, rf_write_data, wb_done, clear_busy, instret, dbg_state);
    end
  endtask

  task automatic test_no_capture();
    @(negedge clk);
    wb_enable = 1'b1; memory_done = 1'b0; reg_write = 1'b1; rd = 5'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (rf_write_enable !== 1'b0 || dbg_state !== 2'(IDLE) || instret !== exp_instret) begin
        errors++;
        $display("FAIL no_capture_%0d: we=%b state=%0d instret=%h, need we=0 IDLE instret=%h",
                 i, rf_write_enable, dbg_state, instret, exp_instret);
      end
    end
    idle_inputs();
  endtask

  task automatic test_alu();
    retire(64'h1234, 64'h0, 64'h0, 5'd5, 1'b1, 1'b0, 1'b0, 3'd0, 0, "alu");
    checks++;
    if (instret !== 64'd1) begin
      errors++;
      $display("FAIL alu_instret: got %h need 1", instret);
    end
  endtask

  task automatic test_loads();
    retire(64'h1, 64'h0, 64'h0000_0000_0080_FF00, 5'd7, 1'b1, 1'b1, 1'b0, 3'b000, 0, "lb");
    retire(64'h1, 64'h0, 64'h0000_0000_0080_FF00, 5'd7, 1'b1, 1'b1, 1'b0, 3'b100, 0, "lbu");
    retire(64'h2, 64'h0, 64'h0000_0000_0080_FF00, 5'd8, 1'b1, 1'b1, 1'b0, 3'b001, 0, "lh");
    retire(64'h6, 64'h0, 64'h8899_AABB_CCDD_EEFF, 5'd9, 1'b1, 1'b1, 1'b0, 3'b010, 0, "lw_cross");
    retire(64'h3, 64'h0, 64'h8899_AABB_CCDD_EEFF, 5'd9, 1'b1, 1'b1, 1'b0, 3'b111, 0, "ld_alt");
  endtask

  task automatic test_jump();
    retire(64'h55, 64'h8000_0000, 64'h0, 5'd1, 1'b1, 1'b1, 1'b1, 3'd0, 0, "jump_x1");
    retire(64'h55, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 5'd2, 1'b1, 1'b0, 1'b1, 3'd0, 0, "jump_wrap");
    retire(64'h55, 64'h8000_0000, 64'h0, 5'd0, 1'b1, 1'b0, 1'b1, 3'd0, 0, "jump_x0");
  endtask

  task automatic test_hold();
    retire(64'hABCD, 64'h0, 64'h0, 5'd12, 1'b1, 1'b0, 1'b0, 3'd0, 4, "hold");
  endtask

  task automatic test_reset_in_write();
    @(negedge clk);
    alu_data = 64'h77; rd = 5'd4; reg_write = 1'b1; mem_to_reg = 1'b0; jump = 1'b0;
    wb_enable = 1'b1; memory_done = 1'b1;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checks++;
    if (rf_write_enable !== 1'b0 || clear_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_write_strobe: we=%b cb=%b, need 0 0", rf_write_enable, clear_busy);
    end
    @(posedge clk);
    #1 reset = 1'b0; idle_inputs();
    exp_instret = '0;
    @(negedge clk);
    checks++;
    if (dbg_state !== 2'(IDLE) || instret !== 64'd0 || wb_done !== 1'b0 || rf_write_enable !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_write_after: state=%0d instret=%h done=%b we=%b, need IDLE 0 0 0",
               dbg_state, instret, wb_done, rf_write_enable);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      retire({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
             RW'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), $urandom_range(0, 3), "rand");
    end
  endtask

  task automatic test_instret_wrap();
    @(negedge clk);
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut.instret_q;
    exp_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    retire(64'h1, 64'h0, 64'h0, 5'd3, 1'b1, 1'b0, 1'b0, 3'd0, 0, "wrap");
    checks++;
    if (instret !== 64'd0) begin
      errors++;
      $display("FAIL instret_wrap: got %h need 0", instret);
    end
  endtask

  initial begin
    test_reset();
    test_no_capture();
    test_alu();
    test_loads();
    test_jump();
    test_hold();
    test_reset_in_write();
    test_random();
    test_instret_wrap();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_writes: %0d expected writes never seen, need 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
